sd_cmd_arbiter: RTL
===================

Name: sd_cmd_arbiter

Overview:
- Shares the single sd_cmd_master command path between NREQ requesters, e.g. the Wishbone register interface (req 0) and the data-transfer engine's auto CMD12/CMD13 issue (req 1).
- Arbitrates, drives the master's command inputs, waits for completion or error, and captures the status and response for the winning requester.
- Clears the master's interrupt status before accepting the next request.
- Sits between the requesters and sd_cmd_master in the sd_clk domain.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- IDX_W, 2, width of the grant index; must be ≥ clog2(NREQ).

Ports:
- sd_clk  in  1  controller clock.
- rst  in  1  reset; asynchronous, active-low.
- req_i  in  NREQ  level request per requester; held until that requester's done_o.
- req_argument_i  in  NREQ*32  per-requester argument; slice k = [32k+31:32k].
- req_command_i  in  NREQ*14  per-requester command word, same format as the master's command_i.
- req_timeout_i  in  NREQ*16  per-requester timeout in sd_clk cycles.
- gnt_o  out  NREQ  one-hot; marks the requester currently owning the master.
- done_o  out  NREQ  one-cycle pulse to the owner when its command finishes.
- status_o  out  5  captured int_status: bit0 CC, bit1 EI, bit2 CTE, bit3 CCRC, bit4 CIE.
- resp_0_o, resp_1_o, resp_2_o, resp_3_o  out  32 each  captured response words.
- m_start_o  out  1  start_i of the master.
- m_int_status_rst_o  out  1  int_status_rst_i of the master.
- m_argument_o  out  32  argument to the master.
- m_command_o  out  14  command to the master.
- m_timeout_o  out  16  timeout to the master.
- m_int_status_i  in  5  int_status_o of the master.
- m_response_0_i .. m_response_3_i  in  32 each  response words of the master.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0.
  - State IDLE.
  - Last-grant pointer = NREQ-1, so requester 0 wins first.
- States and transitions:
  - IDLE: when any req_i bit is set, pick the winner round-robin, searching from last+1 with wrap at NREQ.
    - Register the winner's argument, command and timeout onto m_*_o.
    - Set gnt_o[winner].
    - Pulse m_start_o for exactly one cycle, in the cycle after req is sampled.
    - Update last = winner. Go to WAIT.
  - WAIT: hold gnt_o and the m_* buses stable.
    - When m_int_status_i[0] or m_int_status_i[1] is set, capture m_int_status_i into status_o and m_response_*_i into resp_*_o.
    - Pulse done_o[winner] for one cycle in that same registered update. Go to CLR.
  - CLR: pulse m_int_status_rst_o for one cycle.
    - Clear gnt_o; m_argument_o, m_command_o and m_timeout_o return to 0.
    - Go to IDLE.
- Latency:
  - req to m_start_o: 1 cycle.
  - Master completion to done_o: 1 cycle.
  - done_o to the next possible m_start_o: 2 cycles (CLR, then IDLE sampling).
- status_o and resp_*_o hold until the next capture. They are shared; a requester reads them in its done_o cycle or later, before its next request completes.
- Error completion (EI set, with CTE, CCRC or CIE) is treated like normal completion; status_o carries the error bits.
- req_i dropped while granted: ignored. The command runs to completion and done_o still pulses.
- req_i dropped before grant: the request is withdrawn, with no effect.
- A requester re-asserting in the same cycle as done_o is arbitrated normally at the next IDLE. With other requesters pending, round-robin defers it.
- m_int_status_i nonzero while IDLE (stale status) is ignored; the CLR state guarantees it is clear before the next start.
- Reset mid-WAIT: all state dropped with no done_o pulse. The master is reset by the same rst.

Optional Feature:
- Macro: SD_CMD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the last-grant pointer is not implemented.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package sd_cmd_arb_pkg:
  - State enum {IDLE, WAIT, CLR}.
  - Int-status bit index constants (CC=0, EI=1, CTE=2, CCRC=3, CIE=4).
  - Width constants ARG_W=32, CMD_W=14, TMO_W=16.
- One sub-module: sd_rr_pick, combinational. Inputs: req vector and last index. Outputs: one-hot winner plus its index. Holds the fixed-priority variant under the macro.

Test Plan:
- Single request: req_i=01, arg0=32'h01234567, cmd0=14'h0100, tmo0=100.
  - Expect m_start_o pulse 1 cycle later with m_argument_o=32'h01234567 and m_command_o=14'h0100.
  - Model sets m_int_status_i=5'b00001 after 10 cycles → done_o=01 1 cycle later, status_o=5'b00001, then an m_int_status_rst_o pulse.
- Response capture: req 1 with cmd=14'h0501; model returns responses 32'h01020304/05060708/090a0b0c/0d0e0f00 with CC.
  - Expect resp_*_o equal to those words and done_o=10.
- Contention: req_i=11 asserted together, held.
  - Expect grant order 0, 1, 0, 1 across four completions.
  - With SD_CMD_ARB_FIXED_PRIO_EN: 0, 0, 0.
- Timeout error: model returns 5'b00110.
  - Expect status_o=5'b00110, done_o pulse, m_int_status_rst_o pulse, and the next request started normally.
- Withdrawal: req 1 dropped while req 0 is owned, then req 0 dropped in WAIT.
  - Expect req 0's done_o still pulses and req 1 is never granted.
- Async reset asserted in WAIT.
  - Expect all outputs 0 immediately and no done_o.
  - After release, req_i=11 grants requester 0 first.

Source files
------------

// File: rtl/sd_cmd_arb_pkg.sv
// Shared types and constants for the SD command-path arbiter.
package sd_cmd_arb_pkg;

    localparam int unsigned ARG_W  = 32;
    localparam int unsigned CMD_W  = 14;
    localparam int unsigned TMO_W  = 16;
    localparam int unsigned STAT_W = 5;
    localparam int unsigned RESP_W = 32;

    // Bit positions inside the master's int_status word.
    localparam int unsigned INT_CC   = 0;
    localparam int unsigned INT_EI   = 1;
    localparam int unsigned INT_CTE  = 2;
    localparam int unsigned INT_CCRC = 3;
    localparam int unsigned INT_CIE  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CLR  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sd_rr_pick.sv
// Combinational winner selection for the command-path arbiter.
// SD_CMD_ARB_FIXED_PRIO_EN: lowest index wins and last_i is ignored;
// otherwise round-robin starting at last_i+1 with wrap at NREQ.
module sd_rr_pick
    import sd_cmd_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [NREQ-1:0]  win_oh_o,
    output logic [IDX_W-1:0] win_idx_o
);

`ifdef SD_CMD_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_i;

    // First set request from index 0 upward wins.
    always_comb begin
        logic found;
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        for (int j = 0; j < int'(NREQ); j++) begin
            if (!found && req_i[j]) begin
                found       = 1'b1;
                win_oh_o[j] = 1'b1;
                win_idx_o   = IDX_W'(j);
            end
        end
    end
`else
    // Scan offsets 1..NREQ past the last grant; first pending request wins.
    always_comb begin
        logic found;
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            for (int j = 0; j < int'(NREQ); j++) begin
                if (!found && req_i[j] && (j == ((int'(last_i) + i) % int'(NREQ)))) begin
                    found       = 1'b1;
                    win_oh_o[j] = 1'b1;
                    win_idx_o   = IDX_W'(j);
                end
            end
        end
    end
`endif

endmodule

// File: rtl/sd_cmd_arbiter.sv
// Shares one sd_cmd_master between NREQ requesters: grant, launch,
// wait for completion/error, capture status+response, clear master status.
// SD_CMD_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module sd_cmd_arbiter
    import sd_cmd_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = 2
) (
    input  logic                   sd_clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*ARG_W-1:0]  req_argument_i,
    input  logic [NREQ*CMD_W-1:0]  req_command_i,
    input  logic [NREQ*TMO_W-1:0]  req_timeout_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic [NREQ-1:0]        done_o,
    output logic [STAT_W-1:0]      status_o,
    output logic [RESP_W-1:0]      resp_0_o,
    output logic [RESP_W-1:0]      resp_1_o,
    output logic [RESP_W-1:0]      resp_2_o,
    output logic [RESP_W-1:0]      resp_3_o,
    output logic                   m_start_o,
    output logic                   m_int_status_rst_o,
    output logic [ARG_W-1:0]       m_argument_o,
    output logic [CMD_W-1:0]       m_command_o,
    output logic [TMO_W-1:0]       m_timeout_o,
    input  logic [STAT_W-1:0]      m_int_status_i,
    input  logic [RESP_W-1:0]      m_response_0_i,
    input  logic [RESP_W-1:0]      m_response_1_i,
    input  logic [RESP_W-1:0]      m_response_2_i,
    input  logic [RESP_W-1:0]      m_response_3_i
);

    arb_state_e         state_q;
    logic [NREQ-1:0]    gnt_q;
    logic [NREQ-1:0]    done_q;
    logic [STAT_W-1:0]  status_q;
    logic [RESP_W-1:0]  resp0_q, resp1_q, resp2_q, resp3_q;
    logic               m_start_q;
    logic               m_int_rst_q;
    logic [ARG_W-1:0]   m_arg_q;
    logic [CMD_W-1:0]   m_cmd_q;
    logic [TMO_W-1:0]   m_tmo_q;

    logic [NREQ-1:0]    win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   last_sel;
    logic [ARG_W-1:0]   arg_d;
    logic [CMD_W-1:0]   cmd_d;
    logic [TMO_W-1:0]   tmo_d;
    logic               done_evt;

`ifdef SD_CMD_ARB_FIXED_PRIO_EN
    logic unused_idx;
    assign unused_idx = ^win_idx;
    assign last_sel   = '0;
`else
    logic [IDX_W-1:0]   last_q;
    assign last_sel   = last_q;
`endif

    sd_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i     (req_i),
        .last_i    (last_sel),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx)
    );

    // Select the winner's argument, command and timeout slices.
    always_comb begin
        arg_d = '0;
        cmd_d = '0;
        tmo_d = '0;
        for (int j = 0; j < int'(NREQ); j++) begin
            if (win_oh[j]) begin
                arg_d = req_argument_i[j*ARG_W +: ARG_W];
                cmd_d = req_command_i[j*CMD_W +: CMD_W];
                tmo_d = req_timeout_i[j*TMO_W +: TMO_W];
            end
        end
    end

    assign done_evt = m_int_status_i[INT_CC] | m_int_status_i[INT_EI];

    // Arbitration FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge sd_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            status_q    <= '0;
            resp0_q     <= '0;
            resp1_q     <= '0;
            resp2_q     <= '0;
            resp3_q     <= '0;
            m_start_q   <= 1'b0;
            m_int_rst_q <= 1'b0;
            m_arg_q     <= '0;
            m_cmd_q     <= '0;
            m_tmo_q     <= '0;
`ifndef SD_CMD_ARB_FIXED_PRIO_EN
            last_q      <= IDX_W'(NREQ - 1);
`endif
        end else begin
            m_start_q   <= 1'b0;
            m_int_rst_q <= 1'b0;
            done_q      <= '0;
            case (state_q)
                IDLE: begin
                    // Stale master status is ignored here; CLR already reset it.
                    if (|req_i) begin
                        gnt_q     <= win_oh;
                        m_arg_q   <= arg_d;
                        m_cmd_q   <= cmd_d;
                        m_tmo_q   <= tmo_d;
                        m_start_q <= 1'b1;
`ifndef SD_CMD_ARB_FIXED_PRIO_EN
                        last_q    <= win_idx;
`endif
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    // Error completion is treated like normal completion.
                    if (done_evt) begin
                        status_q <= m_int_status_i;
                        resp0_q  <= m_response_0_i;
                        resp1_q  <= m_response_1_i;
                        resp2_q  <= m_response_2_i;
                        resp3_q  <= m_response_3_i;
                        done_q   <= gnt_q;
                        state_q  <= CLR;
                    end
                end
                CLR: begin
                    m_int_rst_q <= 1'b1;
                    gnt_q       <= '0;
                    m_arg_q     <= '0;
                    m_cmd_q     <= '0;
                    m_tmo_q     <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o              = gnt_q;
    assign done_o             = done_q;
    assign status_o           = status_q;
    assign resp_0_o           = resp0_q;
    assign resp_1_o           = resp1_q;
    assign resp_2_o           = resp2_q;
    assign resp_3_o           = resp3_q;
    assign m_start_o          = m_start_q;
    assign m_int_status_rst_o = m_int_rst_q;
    assign m_argument_o       = m_arg_q;
    assign m_command_o        = m_cmd_q;
    assign m_timeout_o        = m_tmo_q;

endmodule
